// File: rtl/cpu_pkg.sv
// Shared miniRV core definitions: datapath width, canonical NOP and the
// fetch->decode payload record reused by the stage buffers.
package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } if_id_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/count bookkeeping for a small power-of-two FIFO with a
// synchronous flush that wins over both push and pop.
module fifo_ctrl #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic          flush,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign push   = push_req && !full && !flush;
    assign pop    = pop_req && !empty && !flush;
    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_id_buf.sv
// Fetch->decode decoupling FIFO: registered payload storage with a
// combinational head read, valid/ready on both sides, flush on redirect.
module if_id_buf
    import cpu_pkg::*;
#(
    parameter  int              DEPTH    = 2,
    parameter  logic [XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST,
    localparam int              AW       = $clog2(DEPTH),
    localparam int              CW       = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    input  logic [XLEN-1:0] if_pc4,
    output logic            if_ready,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc4,
    input  logic            id_ready,
    output logic [CW-1:0]   occupancy
);

    logic          push, pop, full, empty;
    logic [AW-1:0] wr_ptr, rd_ptr;
    if_id_t        mem_q [DEPTH];
    if_id_t        head;

    fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .push_req (if_valid),
        .pop_req  (id_ready),
        .flush    (flush),
        .push     (push),
        .pop      (pop),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (occupancy),
        .full     (full),
        .empty    (empty)
    );

    // Fullness alone gates fetch, so a same-cycle pop never frees a slot.
    assign if_ready = !full && rst;
    assign id_valid = !empty && !flush;

    // Storage is intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= '{pc: if_pc, inst: if_inst, pc4: if_pc4};
    end

    always_comb begin
        head    = mem_q[rd_ptr];
        id_pc   = '0;
        id_inst = NOP_INST;
        id_pc4  = '0;
        if (id_valid) begin
            id_pc   = head.pc;
            id_inst = head.inst;
            id_pc4  = head.pc4;
        end
    end

endmodule
